// File: rtl/uart_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_console: CPU6-bus console with TX FIFO, 8N1 serialiser and halt.    |
// | Optional UART_CONSOLE_SIM_PRINT_EN echoes pushed bytes and ends the sim.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_console #(
    parameter logic [15:0] BASE_ADDR    = 16'h5a00,
    parameter logic [15:0] HALT_ADDR    = 16'h5b00,
    parameter logic [7:0]  HALT_CODE    = 8'h5a,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        writeEn,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    output logic        select,
    output logic        txd,
    output logic        halt
);
    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [15:0]     STATUS_ADDR = BASE_ADDR + 16'd1;
    localparam logic [1:0]      S_IDLE      = 2'd0;
    localparam logic [1:0]      S_START     = 2'd1;
    localparam logic [1:0]      S_DATA      = 2'd2;
    localparam logic [1:0]      S_STOP      = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          overflow;
    logic          halt_pending;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          bit_done;
    logic          tx_busy;
    logic          halt_set;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_req = writeEn && (address == BASE_ADDR);
    assign push_ok  = push_req && !full;
    assign pop      = (state == S_IDLE) && !empty;
    assign bit_done = (clk_cnt == CNT_LAST);
    assign halt_set = halt_pending && empty && (state == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
            if (push_req && full)
                overflow <= 1'b1;
            else if (writeEn && (address == STATUS_ADDR))
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wptr[AW-1:0]] <= dataIn;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (state == S_IDLE) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            if (pop)
                shreg <= mem[rptr[AW-1:0]];
        end else if (bit_done) begin
            clk_cnt <= '0;
            if (state == S_DATA) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!empty) state_next = S_START;
            S_START: if (bit_done) state_next = S_DATA;
            S_DATA:  if (bit_done && (bit_idx == 3'd7)) state_next = S_STOP;
            S_STOP:  if (bit_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        txd     = 1'b1;
        tx_busy = (state != S_IDLE);
        case (state)
            S_START: txd = 1'b0;
            S_DATA:  txd = shreg[0];
            default: txd = 1'b1;
        endcase
    end

    // Status is sampled from pre-edge state, so same-cycle push/pop is not visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataOut      <= 8'h00;
            select       <= 1'b0;
            halt_pending <= 1'b0;
            halt         <= 1'b0;
        end else begin
            select  <= (address == BASE_ADDR) || (address == STATUS_ADDR);
            dataOut <= (address == STATUS_ADDR) ?
                       {4'b0000, overflow, tx_busy, full, empty} : 8'h00;
            if (writeEn && (address == HALT_ADDR) && (dataIn == HALT_CODE))
                halt_pending <= 1'b1;
            if (halt_set)
                halt <= 1'b1;
        end
    end

`ifdef UART_CONSOLE_SIM_PRINT_EN
    always @(posedge clock) begin
        if (!reset && push_ok)
            $write("%s", dataIn);
        if (!reset && !halt && halt_set) begin
            $display("Simulation terminated by user request.");
            $finish;
        end
    end
`else
    // Synthesis build: halt is only exported on its port.
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_console: frame-timeline model plus directed console/halt tests.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_console;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        writeEn = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic [7:0]  dataOut;
    logic        select;
    logic        txd;
    logic        halt;

    uart_console #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .address (address),
        .writeEn (writeEn),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .select  (select),
        .txd     (txd),
        .halt    (halt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: each accepted byte becomes a frame with its write edge and pop edge.
    int         f_wr[$];
    int         f_st[$];
    logic [7:0] f_byte[$];
    int         ov_e[$];
    logic       ov_v[$];
    int         last_start = -1000;
    int         armed = -1;
    logic       model_halt = 1'b0;

    int          cyc = 0;
    logic        rst_at = 1'b0;
    logic [15:0] addr_at = 16'h0000;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_at  <= reset;
        addr_at <= address;
    end

    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int occ(int k);
        int n = 0;
        foreach (f_wr[i]) if (f_wr[i] < k && f_st[i] >= k) n++;
        return n;
    endfunction

    function automatic logic busy(int k);
        logic b = 1'b0;
        foreach (f_st[i]) if (f_st[i] < k && k <= f_st[i] + FRAME) b = 1'b1;
        return b;
    endfunction

    function automatic logic quiet(int k);
        logic q = 1'b1;
        foreach (f_st[i]) if (f_wr[i] < k && k <= f_st[i] + FRAME) q = 1'b0;
        return q;
    endfunction

    function automatic logic ovf_before(int k);
        logic v = 1'b0;
        foreach (ov_e[i]) if (ov_e[i] < k) v = ov_v[i];
        return v;
    endfunction

    function automatic logic [7:0] status_model(int k);
        int n;
        n = occ(k);
        return {4'b0000, ovf_before(k), busy(k), (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic txd_model(int k);
        logic r = 1'b1;
        foreach (f_st[i]) begin
            if (k >= f_st[i] && k < f_st[i] + FRAME) begin
                int b;
                b = (k - f_st[i]) / CPB;
                if (b == 0)      r = 1'b0;
                else if (b <= 8) r = f_byte[i][b-1];
                else             r = 1'b1;
            end
        end
        return r;
    endfunction

    // Compare process: every cycle, DUT outputs after edge cyc versus the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            logic       e_txd;
            logic       e_sel;
            logic [7:0] e_do;
            if (rst_at) begin
                model_halt = 1'b0;
                e_txd = 1'b1;
                e_sel = 1'b0;
                e_do  = 8'h00;
            end else begin
                if (armed >= 0 && cyc > armed && quiet(cyc))
                    model_halt = 1'b1;
                e_txd = txd_model(cyc);
                e_sel = (addr_at == 16'h5a00) || (addr_at == 16'h5a01);
                e_do  = (addr_at == 16'h5a01) ? status_model(cyc) : 8'h00;
            end
            lit("txd", {7'd0, txd}, {7'd0, e_txd});
            lit("halt", {7'd0, halt}, {7'd0, model_halt});
            lit("select", {7'd0, select}, {7'd0, e_sel});
            lit("dataOut", dataOut, e_do);
        end
    end

    // One bus cycle, captured at the next posedge; returns just after the following negedge.
    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        int k;
        int st;
        k = cyc + 1;
        if (w && a == 16'h5a00) begin
            if (occ(k) == DEPTH) begin
                ov_e.push_back(k);
                ov_v.push_back(1'b1);
            end else begin
                st = (k + 1 > last_start + FRAME + 1) ? k + 1 : last_start + FRAME + 1;
                f_wr.push_back(k);
                f_st.push_back(st);
                f_byte.push_back(d);
                last_start = st;
            end
        end
        if (w && a == 16'h5a01) begin
            ov_e.push_back(k);
            ov_v.push_back(1'b0);
        end
        if (w && a == 16'h5b00 && d == 8'h5a && armed < 0)
            armed = k;
        address = a;
        writeEn = w;
        dataIn  = d;
        @(negedge clk);
        #1;
        address = 16'h0000;
        writeEn = 1'b0;
        dataIn  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) bus(16'h0000, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        f_wr.delete();
        f_st.delete();
        f_byte.delete();
        last_start = -1000;
        armed = -1;
        ov_e.push_back(cyc + 1);
        ov_v.push_back(1'b0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_status(input string nm, input logic [7:0] exp, input int limit);
        int n = 0;
        do begin
            bus(16'h5a01, 1'b0, 8'h00);
            n++;
        end while (dataOut !== exp && n < limit);
        lit(nm, dataOut, exp);
    endtask

    initial begin
        logic [9:0] pat;
        int p;
        pat = {1'b1, 8'h41, 1'b0};
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;

        // Reset state and idle status
        lit("reset_txd", {7'd0, txd}, 8'h01);
        bus(16'h5a01, 1'b0, 8'h00);
        lit("reset_status", dataOut, 8'h01);
        lit("reset_select", {7'd0, select}, 8'h01);

        // Single byte 0x41: start bit follows the write by one edge
        bus(16'h5a00, 1'b1, 8'h41);
        lit("pre_start_txd", {7'd0, txd}, 8'h01);
        bus(16'h5a01, 1'b0, 8'h00);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                lit("frame_41_bit", {7'd0, txd}, {7'd0, pat[b]});
                if (b == 5 && c == 0)
                    lit("mid_frame_status", dataOut, 8'h05);
                bus(16'h5a01, 1'b0, 8'h00);
            end
        end
        lit("post_frame_txd", {7'd0, txd}, 8'h01);
        bus(16'h5a01, 1'b0, 8'h00);
        lit("post_frame_status", dataOut, 8'h01);

        // Nine back-to-back bytes fit: FIFO full, busy, no overflow
        for (int i = 0; i < 9; i++)
            bus(16'h5a00, 1'b1, 8'h30 + 8'(i));
        bus(16'h5a01, 1'b0, 8'h00);
        lit("full_status", dataOut, 8'h06);
        wait_status("drain9_status", 8'h01, 600);

        // Ten bytes: tenth dropped, overflow sticky until cleared
        for (int i = 0; i < 10; i++)
            bus(16'h5a00, 1'b1, 8'hc0 + 8'(i));
        bus(16'h5a01, 1'b0, 8'h00);
        lit("overflow_status", dataOut, 8'h0e);
        bus(16'h5a01, 1'b1, 8'hff);
        lit("clear_edge_status", dataOut, 8'h0e);
        bus(16'h5a01, 1'b0, 8'h00);
        lit("cleared_status", dataOut, 8'h06);
        wait_status("drain10_status", 8'h01, 600);

        // Wrong halt code never halts
        bus(16'h5b00, 1'b1, 8'h00);
        idle(3);
        lit("no_halt", {7'd0, halt}, 8'h00);

        // Arm halt with three bytes queued
        p = cyc + 1;
        bus(16'h5a00, 1'b1, 8'h55);
        bus(16'h5a00, 1'b1, 8'haa);
        bus(16'h5a00, 1'b1, 8'h0f);
        bus(16'h5b00, 1'b1, 8'h5a);
        while (cyc < p + 123)
            idle(1);
        lit("halt_before_rise", {7'd0, halt}, 8'h00);
        idle(1);
        lit("halt_risen", {7'd0, halt}, 8'h01);
        idle(5);
        lit("halt_sticky", {7'd0, halt}, 8'h01);

        // Reset mid-DATA abandons the frame and the queue
        bus(16'h5a00, 1'b1, 8'h12);
        bus(16'h5a00, 1'b1, 8'h34);
        bus(16'h5a00, 1'b1, 8'h56);
        idle(10);
        do_reset();
        lit("mid_reset_txd", {7'd0, txd}, 8'h01);
        lit("mid_reset_halt", {7'd0, halt}, 8'h00);
        bus(16'h5a01, 1'b0, 8'h00);
        lit("mid_reset_status", dataOut, 8'h01);
        idle(100);
        lit("abandoned_txd", {7'd0, txd}, 8'h01);

        // Address decode
        bus(16'h1234, 1'b0, 8'h00);
        lit("foreign_select", {7'd0, select}, 8'h00);
        lit("foreign_data", dataOut, 8'h00);
        bus(16'h5a07, 1'b0, 8'h00);
        lit("offset7_select", {7'd0, select}, 8'h00);
        bus(16'h5a00, 1'b0, 8'h00);
        lit("base_select", {7'd0, select}, 8'h01);
        lit("base_data", dataOut, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
